alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid FIFO that registers the ALU result, flags,
// destination and a jump decision. Define JUMP_CNT_EN to add the jump_cnt counter port.
module alu_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [2:0]  dest_in,
  input  logic [2:0]  jmp_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] res_out,
  output logic        zr_out,
  output logic        ng_out,
  output logic [2:0]  dest_out,
  output logic        jump_taken,
  output logic        out_valid,
  input  logic        out_ready
`ifdef JUMP_CNT_EN
  ,
  output logic [15:0] jump_cnt
`endif
);

  typedef struct packed {
    logic [15:0] res;
    logic        zr;
    logic        ng;
    logic [2:0]  dest;
    logic        jump;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      new_entry;
  entry_t      head;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        init_q;
  logic        push, pop;

  // init_q keeps in_ready low while in reset and releases it on the first edge after.
  assign in_ready  = init_q && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: storage is not reset; outputs are masked by out_valid instead, so the
  // reset value is defined without clearing the data array.
  assign res_out    = out_valid ? head.res  : 16'h0000;
  assign zr_out     = out_valid ? head.zr   : 1'b0;
  assign ng_out     = out_valid ? head.ng   : 1'b0;
  assign dest_out   = out_valid ? head.dest : 3'b000;
  assign jump_taken = out_valid ? head.jump : 1'b0;

  always_comb begin
    new_entry.res  = alu_out;
    new_entry.zr   = alu_zr;
    new_entry.ng   = alu_ng;
    new_entry.dest = dest_in;
    new_entry.jump = (jmp_in[2] & alu_ng) | (jmp_in[1] & alu_zr) |
                     (jmp_in[0] & ~alu_ng & ~alu_zr);
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) mem_d[wr_ptr_q] = new_entry;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      init_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      init_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef JUMP_CNT_EN
  logic [15:0] jump_cnt_q, jump_cnt_d;

  always_comb begin
    jump_cnt_d = jump_cnt_q;
    if (pop && head.jump && (jump_cnt_q != 16'hFFFF)) jump_cnt_d = jump_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) jump_cnt_q <= 16'h0000;
    else     jump_cnt_q <= jump_cnt_d;
  end

  assign jump_cnt = jump_cnt_q;
`endif

endmodule
